// File: rtl/harmonic_sequencer.sv
// Steps a one-hot MOSFET drive pattern table on NCO ticks, with all-off dead time between differing drives.
// Latency: drives go off one clock after a changing tick; the new pattern appears DEAD_CYCLES clocks after that.
// Backpressure: none; ticks that arrive during dead time are dropped and flagged in tickOverrun.
module harmonic_sequencer #(
    parameter int STEPS = 6,
    parameter int DEAD_CYCLES = 2,
    localparam int IDX_W = $clog2(STEPS)
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             enable,
    input  logic             abort,
    input  logic             stepTick,
    input  logic             cfgWrite,
    input  logic [3:0]       cfgAddr,
    input  logic [3:0]       cfgData,
    input  logic             clearFaults,
    output logic             pushBase,
    output logic             pushPeak,
    output logic             pullBase,
    output logic             pullPeak,
    output logic [IDX_W-1:0] stepIndex,
    output logic             running,
    output logic             cycleStart,
    output logic             patternFault,
    output logic             tickOverrun
);

    typedef enum logic [1:0] {IDLE, DEAD, DRIVE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(STEPS - 1);
    localparam logic [3:0]       DEAD_LOAD = 4'(DEAD_CYCLES - 1);

    state_t           state, stateNext;
    logic [IDX_W-1:0] idxNext, advIdx;
    logic [3:0]       deadCnt, deadCntNext;
    logic [3:0]       drives, drivesNext;
    logic             runNext, csNext, pfNext, toNext;
    logic             pfEvt, toEvt, wrap;
    logic [3:0]       loadPat, advPat;
    logic [3:0]       patTable [STEPS];

    function automatic logic isIllegal(input logic [3:0] p);
        return (p & (p - 4'd1)) != 4'd0;
    endfunction

    function automatic logic [3:0] masked(input logic [3:0] p);
        return isIllegal(p) ? 4'd0 : p;
    endfunction

    // Default waveform: +1,+2,+1,-1,-2,-1
    function automatic logic [3:0] resetPattern(input int i);
        case (i)
            0:       return 4'b0001;
            1:       return 4'b0010;
            2:       return 4'b0001;
            3:       return 4'b0100;
            4:       return 4'b1000;
            5:       return 4'b0100;
            default: return 4'b0000;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < STEPS; i++) patTable[i] <= resetPattern(i);
        end else if (cfgWrite && (int'(cfgAddr) < STEPS)) begin
            patTable[cfgAddr[IDX_W-1:0]] <= cfgData;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state        <= IDLE;
            stepIndex    <= '0;
            deadCnt      <= '0;
            drives       <= '0;
            running      <= 1'b0;
            cycleStart   <= 1'b0;
            patternFault <= 1'b0;
            tickOverrun  <= 1'b0;
        end else begin
            state        <= stateNext;
            stepIndex    <= idxNext;
            deadCnt      <= deadCntNext;
            drives       <= drivesNext;
            running      <= runNext;
            cycleStart   <= csNext;
            patternFault <= pfNext;
            tickOverrun  <= toNext;
        end
    end

    always_comb begin
        stateNext   = state;
        idxNext     = stepIndex;
        deadCntNext = deadCnt;
        drivesNext  = drives;
        runNext     = running;
        csNext      = 1'b0;
        pfEvt       = 1'b0;
        toEvt       = 1'b0;
        wrap        = (stepIndex == LAST_IDX);
        advIdx      = wrap ? '0 : stepIndex + IDX_W'(1);
        loadPat     = patTable[stepIndex];
        advPat      = patTable[advIdx];

        if (abort) begin
            stateNext   = IDLE;
            idxNext     = '0;
            deadCntNext = '0;
            drivesNext  = '0;
            runNext     = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    drivesNext = '0;
                    if (enable && stepTick) begin
                        stateNext   = DEAD;
                        idxNext     = '0;
                        deadCntNext = DEAD_LOAD;
                        runNext     = 1'b1;
                        csNext      = 1'b1;
                    end
                end
                DEAD: begin
                    drivesNext = '0;
                    toEvt      = stepTick;
                    // Table is read at load time so late config writes still land.
                    if (deadCnt == '0) begin
                        stateNext  = DRIVE;
                        drivesNext = masked(loadPat);
                        pfEvt      = isIllegal(loadPat);
                    end else begin
                        deadCntNext = deadCnt - 4'd1;
                    end
                end
                DRIVE: begin
                    if (stepTick) begin
                        if (wrap && !enable) begin
                            stateNext  = IDLE;
                            idxNext    = '0;
                            drivesNext = '0;
                            runNext    = 1'b0;
                        end else begin
                            idxNext = advIdx;
                            csNext  = wrap;
                            // Identical drive needs no dead time; this is its load.
                            if (masked(advPat) == drives) begin
                                pfEvt = isIllegal(advPat);
                            end else begin
                                stateNext   = DEAD;
                                drivesNext  = '0;
                                deadCntNext = DEAD_LOAD;
                            end
                        end
                    end
                end
                default: begin
                    stateNext  = IDLE;
                    drivesNext = '0;
                    runNext    = 1'b0;
                end
            endcase
        end

        pfNext = pfEvt | (patternFault & ~clearFaults);
        toNext = toEvt | (tickOverrun & ~clearFaults);
    end

    assign pushBase = drives[0];
    assign pushPeak = drives[1];
    assign pullBase = drives[2];
    assign pullPeak = drives[3];

endmodule

// File: tb/tb_harmonic_sequencer.sv
// Bench for harmonic_sequencer: directed vector table, hand sequences for reset/abort, randomized run vs reference model.
module tb_harmonic_sequencer;

    localparam int STEPS = 6;
    localparam int DC    = 2;
    localparam int NV    = 24;

    logic       clk = 1'b0;
    logic       rstN;
    logic       enable, abort, stepTick, cfgWrite, clearFaults;
    logic [3:0] cfgAddr, cfgData;
    logic       pushBase, pushPeak, pullBase, pullPeak;
    logic [2:0] stepIndex;
    logic       running, cycleStart, patternFault, tickOverrun;

    int nCmp = 0;
    int nBad = 0;

    harmonic_sequencer #(.STEPS(STEPS), .DEAD_CYCLES(DC)) dut (
        .clk(clk), .rstN(rstN), .enable(enable), .abort(abort), .stepTick(stepTick),
        .cfgWrite(cfgWrite), .cfgAddr(cfgAddr), .cfgData(cfgData), .clearFaults(clearFaults),
        .pushBase(pushBase), .pushPeak(pushPeak), .pullBase(pullBase), .pullPeak(pullPeak),
        .stepIndex(stepIndex), .running(running), .cycleStart(cycleStart),
        .patternFault(patternFault), .tickOverrun(tickOverrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic en, ab, tk, cw;
        logic [3:0] ca, cd;
        logic cf;
        logic [3:0] drv;
        logic [2:0] idx;
        logic run, cs, pf, to;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic en, ab, tk, cw, input logic [3:0] ca, cd, input logic cf,
                                input logic [3:0] drv, input logic [2:0] idx, input logic run, cs, pf, to);
        vec_t v;
        v.en = en; v.ab = ab; v.tk = tk; v.cw = cw; v.ca = ca; v.cd = cd; v.cf = cf;
        v.drv = drv; v.idx = idx; v.run = run; v.cs = cs; v.pf = pf; v.to = to;
        return v;
    endfunction

    function automatic logic [11:0] dutVec();
        return {pullPeak, pullBase, pushPeak, pushBase, stepIndex, running, cycleStart, patternFault, tickOverrun};
    endfunction

    function automatic logic [3:0] dutDrv();
        return {pullPeak, pullBase, pushPeak, pushBase};
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic setIn(input logic en, ab, tk, cw, input logic [3:0] ca, cd, input logic cf);
        enable = en; abort = ab; stepTick = tk; cfgWrite = cw; cfgAddr = ca; cfgData = cd; clearFaults = cf;
    endtask

    task automatic tickClk();
        @(posedge clk);
        #1;
    endtask

    // Reference model: absolute-time schedule of pattern loads rather than a dead counter.
    logic [3:0] mTab [STEPS];
    int         mIdx, mLoadAt, edgeNo;
    bit         mRun, mCs, mPf, mTo;
    logic [3:0] mDrv;

    function automatic logic [3:0] legalOf(input logic [3:0] p);
        return ($countones(p) > 1) ? 4'd0 : p;
    endfunction

    task automatic modelReset();
        mTab = '{4'b0001, 4'b0010, 4'b0001, 4'b0100, 4'b1000, 4'b0100};
        mIdx = 0; mLoadAt = -1; edgeNo = 0;
        mRun = 0; mCs = 0; mPf = 0; mTo = 0; mDrv = 4'd0;
    endtask

    task automatic modelEdge();
        bit pfEvt = 0;
        bit toEvt = 0;
        logic [3:0] p;
        edgeNo++;
        mCs = 0;
        if (abort) begin
            mRun = 0; mIdx = 0; mDrv = 4'd0; mLoadAt = -1;
        end else if (!mRun) begin
            if (enable && stepTick) begin
                mRun = 1; mIdx = 0; mCs = 1; mDrv = 4'd0; mLoadAt = edgeNo + DC;
            end
        end else if (mLoadAt >= 0) begin
            if (stepTick) toEvt = 1;
            if (edgeNo == mLoadAt) begin
                p = mTab[mIdx];
                mDrv = legalOf(p);
                pfEvt = (p != mDrv);
                mLoadAt = -1;
            end
        end else if (stepTick) begin
            if (mIdx == STEPS - 1 && !enable) begin
                mRun = 0; mIdx = 0; mDrv = 4'd0;
            end else begin
                mCs = (mIdx == STEPS - 1);
                mIdx = (mIdx + 1) % STEPS;
                p = mTab[mIdx];
                if (legalOf(p) == mDrv) begin
                    pfEvt = (p != legalOf(p));
                end else begin
                    mDrv = 4'd0;
                    mLoadAt = edgeNo + DC;
                end
            end
        end
        if (clearFaults) begin mPf = 0; mTo = 0; end
        if (pfEvt) mPf = 1;
        if (toEvt) mTo = 1;
        if (cfgWrite && int'(cfgAddr) < STEPS) mTab[cfgAddr] = cfgData;
    endtask

    function automatic logic [11:0] modelVec();
        return {mDrv, 3'(mIdx), mRun, mCs, mPf, mTo};
    endfunction

    logic [3:0] defPat [STEPS];

    initial begin
        defPat = '{4'b0001, 4'b0010, 4'b0001, 4'b0100, 4'b1000, 4'b0100};

        //            en ab tk cw ca    cd     cf | drv    idx run cs pf to
        vecs[0]  = mk(1, 0, 0, 0, 4'd0, 4'd0,  0, 4'h0, 3'd0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 1, 0, 4'd0, 4'd0,  0, 4'h0, 3'd0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 1, 0, 4'd0, 4'd0,  0, 4'h0, 3'd0, 1, 1, 0, 0);
        vecs[3]  = mk(1, 0, 0, 0, 4'd0, 4'd0,  0, 4'h0, 3'd0, 1, 0, 0, 0);
        vecs[4]  = mk(1, 0, 0, 0, 4'd0, 4'd0,  0, 4'h1, 3'd0, 1, 0, 0, 0);
        vecs[5]  = mk(1, 0, 1, 0, 4'd0, 4'd0,  0, 4'h0, 3'd1, 1, 0, 0, 0);
        vecs[6]  = mk(1, 0, 1, 0, 4'd0, 4'd0,  1, 4'h0, 3'd1, 1, 0, 0, 1);
        vecs[7]  = mk(1, 0, 0, 0, 4'd0, 4'd0,  0, 4'h2, 3'd1, 1, 0, 0, 1);
        vecs[8]  = mk(1, 0, 0, 0, 4'd0, 4'd0,  1, 4'h2, 3'd1, 1, 0, 0, 0);
        vecs[9]  = mk(1, 0, 0, 1, 4'd2, 4'd2,  0, 4'h2, 3'd1, 1, 0, 0, 0);
        vecs[10] = mk(1, 0, 1, 0, 4'd0, 4'd0,  0, 4'h2, 3'd2, 1, 0, 0, 0);
        vecs[11] = mk(1, 0, 0, 1, 4'd7, 4'hF,  0, 4'h2, 3'd2, 1, 0, 0, 0);
        vecs[12] = mk(1, 0, 0, 1, 4'd3, 4'h5,  0, 4'h2, 3'd2, 1, 0, 0, 0);
        vecs[13] = mk(1, 0, 1, 0, 4'd0, 4'd0,  0, 4'h0, 3'd3, 1, 0, 0, 0);
        vecs[14] = mk(1, 0, 0, 0, 4'd0, 4'd0,  0, 4'h0, 3'd3, 1, 0, 0, 0);
        vecs[15] = mk(1, 0, 0, 0, 4'd0, 4'd0,  0, 4'h0, 3'd3, 1, 0, 1, 0);
        vecs[16] = mk(1, 0, 1, 0, 4'd0, 4'd0,  0, 4'h0, 3'd4, 1, 0, 1, 0);
        vecs[17] = mk(1, 0, 0, 0, 4'd0, 4'd0,  1, 4'h0, 3'd4, 1, 0, 0, 0);
        vecs[18] = mk(0, 0, 0, 0, 4'd0, 4'd0,  0, 4'h8, 3'd4, 1, 0, 0, 0);
        vecs[19] = mk(0, 0, 1, 0, 4'd0, 4'd0,  0, 4'h0, 3'd5, 1, 0, 0, 0);
        vecs[20] = mk(0, 0, 0, 0, 4'd0, 4'd0,  0, 4'h0, 3'd5, 1, 0, 0, 0);
        vecs[21] = mk(0, 0, 0, 0, 4'd0, 4'd0,  0, 4'h4, 3'd5, 1, 0, 0, 0);
        vecs[22] = mk(0, 0, 1, 0, 4'd0, 4'd0,  0, 4'h0, 3'd0, 0, 0, 0, 0);
        vecs[23] = mk(0, 0, 1, 0, 4'd0, 4'd0,  0, 4'h0, 3'd0, 0, 0, 0, 0);

        rstN = 1'b0;
        setIn(0, 0, 0, 0, 4'd0, 4'd0, 0);
        #7;
        chk("resetState", 16'(dutVec()), 16'h0);
        #5 rstN = 1'b1;
        tickClk();

        for (int i = 0; i < NV; i++) begin
            setIn(vecs[i].en, vecs[i].ab, vecs[i].tk, vecs[i].cw, vecs[i].ca, vecs[i].cd, vecs[i].cf);
            tickClk();
            chk($sformatf("vec%0d", i), 16'(dutVec()),
                16'({vecs[i].drv, vecs[i].idx, vecs[i].run, vecs[i].cs, vecs[i].pf, vecs[i].to}));
        end

        // Async reset mid-DRIVE, then table restore, dead time, abort with a coincident tick.
        setIn(1, 0, 1, 0, 4'd0, 4'd0, 0);
        tickClk();
        setIn(1, 0, 0, 0, 4'd0, 4'd0, 0);
        tickClk();
        tickClk();
        chk("preResetDrive", 16'(dutDrv()), 16'h1);
        #2 rstN = 1'b0;
        #1;
        chk("asyncResetOut", 16'({dutDrv(), stepIndex, running}), 16'h0);
        #2 rstN = 1'b1;
        tickClk();

        setIn(1, 0, 1, 0, 4'd0, 4'd0, 0);
        tickClk();
        setIn(1, 0, 0, 0, 4'd0, 4'd0, 0);
        tickClk();
        tickClk();
        chk("step0", 16'({dutDrv(), stepIndex}), 16'({defPat[0], 3'd0}));
        for (int s = 1; s < 5; s++) begin
            setIn(1, 0, 1, 0, 4'd0, 4'd0, 0);
            tickClk();
            chk($sformatf("dead%0d", s), 16'(dutDrv()), 16'h0);
            setIn(1, 0, 0, 0, 4'd0, 4'd0, 0);
            tickClk();
            tickClk();
            chk($sformatf("step%0d", s), 16'({dutDrv(), stepIndex}), 16'({defPat[s], 3'(s)}));
        end
        setIn(1, 1, 1, 0, 4'd0, 4'd0, 0);
        tickClk();
        chk("abort", 16'({dutDrv(), stepIndex, running, cycleStart}), 16'h0);
        setIn(1, 0, 0, 0, 4'd0, 4'd0, 0);
        tickClk();
        chk("abortIdle", 16'({dutDrv(), running}), 16'h0);

        // Randomized run against the reference model.
        setIn(0, 0, 0, 0, 4'd0, 4'd0, 0);
        #3 rstN = 1'b0;
        modelReset();
        #2 rstN = 1'b1;
        tickClk();
        enable = 1'b1;
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            abort       = ($urandom_range(0, 149) == 0);
            stepTick    = ($urandom_range(0, 3) == 0);
            cfgWrite    = ($urandom_range(0, 24) == 0);
            cfgAddr     = 4'($urandom_range(0, 7));
            cfgData     = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                                      : 4'(4'd1 << $urandom_range(0, 3));
            clearFaults = ($urandom_range(0, 19) == 0);
            modelEdge();
            tickClk();
            chk($sformatf("rand%0d", c), 16'(dutVec()), 16'(modelVec()));
            chk($sformatf("oneHot%0d", c), 16'($countones(dutDrv()) <= 1), 16'h1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
